axi_lite_mem_slave: RTL and testbench

Parametrised AXI4-Lite memory-backed slave and successor to the fixed-width single-FSM slave. Read and write channels run as independent, concurrent state machines, and AW and W are accepted in either order. The block adds WSTRB byte enables and an SLVERR response for out-of-range addresses. It sits behind the AXI4-Lite interconnect as a leaf target.

---
 rtl/axi_lite_pkg.sv | 18 +
 rtl/axi_lite_mem_array.sv | 42 ++++
 rtl/axi_lite_mem_slave.sv | 146 ++++++++++++++
 tb/tb_axi_lite_mem_slave.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite response codes and channel FSM state types.
// Imported by the memory-backed slave and its storage array.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        WR_IDLE,
        WR_RESP
    } wr_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_DATA
    } rd_state_t;

endpackage

// File: rtl/axi_lite_mem_array.sv
// DEPTH x DATA_WIDTH storage: byte-enabled write, registered read
// returning old data on a same-edge write, zeroed on reset.
module axi_lite_mem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 512,
    localparam int IW        = $clog2(DEPTH),
    localparam int BW        = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [IW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [BW-1:0]         wstrb,
    input  logic                  re,
    input  logic [IW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdata <= '0;
        end else begin
            if (re) begin
                rdata <= mem[raddr];
            end
            if (we) begin
                for (int b = 0; b < BW; b++) begin
                    if (wstrb[b]) begin
                        mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite memory-backed leaf slave with independent read/write FSMs,
// AW/W accepted in either order, byte strobes and SLVERR on range miss.
module axi_lite_mem_slave #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 512
) (
    input  logic                    aclk,
    input  logic                    areset_n,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [2:0]              awprot,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [2:0]              arprot,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rvalid,
    input  logic                    rready
);

    import axi_lite_pkg::*;

    localparam int BW  = DATA_WIDTH / 8;
    localparam int OFF = $clog2(BW);
    localparam int IW  = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

    wr_state_t wr_state, wr_next;
    rd_state_t rd_state, rd_next;

    logic                  live_q;
    logic                  aw_held, w_held;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [BW-1:0]         w_strb_q;
    logic                  aw_hs, w_hs, ar_hs, commit;
    logic [ADDR_WIDTH-1:0] wr_addr, wr_idx, rd_idx;
    logic [DATA_WIDTH-1:0] wr_data, mem_q;
    logic [BW-1:0]         wr_strb;
    logic                  wr_ok, rd_ok, rd_err_q;
    logic                  unused_prot;

    assign unused_prot = ^{awprot, arprot};

    // live_q keeps every ready low until the first edge after reset release
    assign awready = live_q && (wr_state == WR_IDLE) && !aw_held;
    assign wready  = live_q && (wr_state == WR_IDLE) && !w_held;
    assign arready = live_q && (rd_state == RD_IDLE);
    assign bvalid  = (wr_state == WR_RESP);
    assign rvalid  = (rd_state == RD_DATA);

    assign aw_hs  = awvalid && awready;
    assign w_hs   = wvalid && wready;
    assign ar_hs  = arvalid && arready;
    assign commit = (aw_held || aw_hs) && (w_held || w_hs);

    assign wr_addr = aw_held ? aw_addr_q : awaddr;
    assign wr_data = w_held ? w_data_q : wdata;
    assign wr_strb = w_held ? w_strb_q : wstrb;
    assign wr_idx  = wr_addr >> OFF;
    assign rd_idx  = araddr >> OFF;
    assign wr_ok   = wr_idx < DEPTH_A;
    assign rd_ok   = rd_idx < DEPTH_A;
    assign rdata   = rd_err_q ? '0 : mem_q;

    axi_lite_mem_array #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) u_mem (
        .clk  (aclk),
        .rst_n(areset_n),
        .we   (commit && wr_ok),
        .waddr(wr_idx[IW-1:0]),
        .wdata(wr_data),
        .wstrb(wr_strb),
        .re   (ar_hs && rd_ok),
        .raddr(rd_idx[IW-1:0]),
        .rdata(mem_q)
    );

    always_comb begin
        wr_next = wr_state;
        unique case (wr_state)
            WR_IDLE: if (commit) wr_next = WR_RESP;
            WR_RESP: if (bready) wr_next = WR_IDLE;
        endcase
    end

    always_comb begin
        rd_next = rd_state;
        unique case (rd_state)
            RD_IDLE: if (ar_hs)  rd_next = RD_DATA;
            RD_DATA: if (rready) rd_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            live_q    <= 1'b0;
            wr_state  <= WR_IDLE;
            rd_state  <= RD_IDLE;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp     <= RESP_OKAY;
            rresp     <= RESP_OKAY;
            rd_err_q  <= 1'b0;
        end else begin
            live_q   <= 1'b1;
            wr_state <= wr_next;
            rd_state <= rd_next;
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bresp   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            end else begin
                if (aw_hs) begin
                    aw_held   <= 1'b1;
                    aw_addr_q <= awaddr;
                end
                if (w_hs) begin
                    w_held   <= 1'b1;
                    w_data_q <= wdata;
                    w_strb_q <= wstrb;
                end
            end
            if (ar_hs) begin
                rresp    <= rd_ok ? RESP_OKAY : RESP_SLVERR;
                rd_err_q <= !rd_ok;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Directed bench for axi_lite_mem_slave: reset, ordering, strobes,
// range errors, backpressure/concurrency and mid-transaction reset.
module tb_axi_lite_mem_slave;

    import axi_lite_pkg::*;

    logic        aclk = 1'b0;
    logic        areset_n = 1'b1;
    logic [11:0] awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [11:0] araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    always #5 aclk = ~aclk;

    axi_lite_mem_slave dut (
        .aclk    (aclk),
        .areset_n(areset_n),
        .awaddr  (awaddr),
        .awprot  (awprot),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready),
        .araddr  (araddr),
        .arprot  (arprot),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready)
    );

    task automatic do_write(input logic [11:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [1:0] r);
        int n;
        logic ag, wg;
        @(negedge aclk);
        awaddr  = a;
        wdata   = d;
        wstrb   = s;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        n = 0;
        while ((awvalid || wvalid) && n < 20) begin
            ag = awvalid && awready;
            wg = wvalid && wready;
            @(posedge aclk); #1;
            if (ag) awvalid = 1'b0;
            if (wg) wvalid = 1'b0;
            n++;
        end
        bready = 1'b1;
        while (!bvalid && n < 40) begin
            @(posedge aclk); #1;
            n++;
        end
        vectors++;
        if (bvalid !== 1'b1) begin
            miscompares++;
            $display("FAIL write_timeout addr=%h got bvalid=%b need 1", a, bvalid);
        end
        r = bresp;
        @(posedge aclk); #1;
        bready  = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
    endtask

    task automatic do_read(input logic [11:0] a, output logic [31:0] d,
                           output logic [1:0] r);
        int n;
        logic g;
        @(negedge aclk);
        araddr  = a;
        arvalid = 1'b1;
        n = 0;
        while (arvalid && n < 20) begin
            g = arvalid && arready;
            @(posedge aclk); #1;
            if (g) arvalid = 1'b0;
            n++;
        end
        rready = 1'b1;
        while (!rvalid && n < 40) begin
            @(posedge aclk); #1;
            n++;
        end
        vectors++;
        if (rvalid !== 1'b1) begin
            miscompares++;
            $display("FAIL read_timeout addr=%h got rvalid=%b need 1", a, rvalid);
        end
        d = rdata;
        r = rresp;
        @(posedge aclk); #1;
        rready  = 1'b0;
        arvalid = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [1:0]  r;
        #2 areset_n = 1'b0;
        #10;
        vectors++;
        if ({awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got %b/%b/%b/%b/%b/%b/%h/%b need all 0",
                     awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp);
        end
        @(negedge aclk);
        areset_n = 1'b1;
        #1;
        vectors++;
        if ({awready, wready, arready} !== 3'b000) begin
            miscompares++;
            $display("FAIL ready_before_edge got %b need 000", {awready, wready, arready});
        end
        @(posedge aclk); #1;
        vectors++;
        if ({awready, wready, arready} !== 3'b111) begin
            miscompares++;
            $display("FAIL ready_after_edge got %b need 111", {awready, wready, arready});
        end
        do_read(12'h010, d, r);
        vectors++;
        if (d !== 32'h0 || r !== RESP_OKAY) begin
            miscompares++;
            $display("FAIL reset_read got %h/%b need 00000000/00", d, r);
        end
    endtask

    task automatic test_w_before_aw();
        logic [31:0] d;
        logic [1:0]  r;
        @(negedge aclk);
        wdata  = 32'hDEADBEEF;
        wstrb  = 4'hF;
        wvalid = 1'b1;
        @(posedge aclk); #1;
        wvalid = 1'b0;
        vectors++;
        if (wready !== 1'b0 || bvalid !== 1'b0 || awready !== 1'b1) begin
            miscompares++;
            $display("FAIL w_held got wready=%b bvalid=%b awready=%b need 0/0/1",
                     wready, bvalid, awready);
        end
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        vectors++;
        if (bvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL early_bvalid got %b need 0", bvalid);
        end
        awaddr  = 12'h010;
        awvalid = 1'b1;
        @(posedge aclk); #1;
        awvalid = 1'b0;
        vectors++;
        if (bvalid !== 1'b1 || bresp !== RESP_OKAY || awready !== 1'b0) begin
            miscompares++;
            $display("FAIL b_latency got bvalid=%b bresp=%b awready=%b need 1/00/0",
                     bvalid, bresp, awready);
        end
        @(negedge aclk);
        bready = 1'b1;
        @(posedge aclk); #1;
        bready = 1'b0;
        vectors++;
        if (bvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL b_drop got bvalid=%b need 0", bvalid);
        end
        do_read(12'h010, d, r);
        vectors++;
        if (d !== 32'hDEADBEEF || r !== RESP_OKAY) begin
            miscompares++;
            $display("FAIL w_first_read got %h/%b need deadbeef/00", d, r);
        end
    endtask

    task automatic test_strobes();
        logic [31:0] d;
        logic [1:0]  r;
        do_write(12'h010, 32'h11223344, 4'b0101, r);
        vectors++;
        if (r !== RESP_OKAY) begin
            miscompares++;
            $display("FAIL strobe_bresp got %b need 00", r);
        end
        do_read(12'h010, d, r);
        vectors++;
        if (d !== 32'hDE22BE44) begin
            miscompares++;
            $display("FAIL strobe_read got %h need de22be44", d);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] d;
        logic [1:0]  r;
        do_write(12'h800, 32'hFFFFFFFF, 4'hF, r);
        vectors++;
        if (r !== RESP_SLVERR) begin
            miscompares++;
            $display("FAIL oor_bresp got %b need 10", r);
        end
        do_read(12'h000, d, r);
        vectors++;
        if (d !== 32'h0 || r !== RESP_OKAY) begin
            miscompares++;
            $display("FAIL oor_alias_word0 got %h/%b need 00000000/00", d, r);
        end
        do_read(12'h010, d, r);
        vectors++;
        if (d !== 32'hDE22BE44) begin
            miscompares++;
            $display("FAIL oor_word4 got %h need de22be44", d);
        end
        do_read(12'h800, d, r);
        vectors++;
        if (d !== 32'h0 || r !== RESP_SLVERR) begin
            miscompares++;
            $display("FAIL oor_read got %h/%b need 00000000/10", d, r);
        end
        do_write(12'h7FC, 32'hA5A5A5A5, 4'hF, r);
        vectors++;
        if (r !== RESP_OKAY) begin
            miscompares++;
            $display("FAIL last_word_bresp got %b need 00", r);
        end
        do_read(12'h7FC, d, r);
        vectors++;
        if (d !== 32'hA5A5A5A5 || r !== RESP_OKAY) begin
            miscompares++;
            $display("FAIL last_word_read got %h/%b need a5a5a5a5/00", d, r);
        end
        do_read(12'h013, d, r);
        vectors++;
        if (d !== 32'hDE22BE44) begin
            miscompares++;
            $display("FAIL unaligned_read got %h need de22be44", d);
        end
    endtask

    task automatic test_concurrency();
        logic [31:0] d;
        logic [1:0]  r;
        @(negedge aclk);
        araddr  = 12'h010;
        arvalid = 1'b1;
        rready  = 1'b0;
        @(posedge aclk); #1;
        arvalid = 1'b0;
        vectors++;
        if (rvalid !== 1'b1) begin
            miscompares++;
            $display("FAIL r_latency got rvalid=%b need 1", rvalid);
        end
        fork
            do_write(12'h020, 32'hCAFEF00D, 4'hF, r);
            for (int i = 0; i < 5; i++) begin
                @(negedge aclk);
                vectors++;
                if (rvalid !== 1'b1 || rdata !== 32'hDE22BE44) begin
                    miscompares++;
                    $display("FAIL r_hold cyc=%0d got %b/%h need 1/de22be44",
                             i, rvalid, rdata);
                end
            end
        join
        vectors++;
        if (r !== RESP_OKAY) begin
            miscompares++;
            $display("FAIL conc_bresp got %b need 00", r);
        end
        @(negedge aclk);
        rready = 1'b1;
        @(posedge aclk); #1;
        rready = 1'b0;
        vectors++;
        if (rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL r_drop got rvalid=%b need 0", rvalid);
        end
        @(negedge aclk);
        vectors++;
        if ({awready, wready, arready} !== 3'b111) begin
            miscompares++;
            $display("FAIL same_edge_ready got %b need 111", {awready, wready, arready});
        end
        araddr  = 12'h020;
        arvalid = 1'b1;
        awaddr  = 12'h020;
        wdata   = 32'h12345678;
        wstrb   = 4'hF;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        bready  = 1'b1;
        rready  = 1'b1;
        @(posedge aclk); #1;
        arvalid = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        vectors++;
        if (rvalid !== 1'b1 || rdata !== 32'hCAFEF00D || bvalid !== 1'b1) begin
            miscompares++;
            $display("FAIL same_edge got rvalid=%b rdata=%h bvalid=%b need 1/cafef00d/1",
                     rvalid, rdata, bvalid);
        end
        @(posedge aclk); #1;
        bready = 1'b0;
        rready = 1'b0;
        do_read(12'h020, d, r);
        vectors++;
        if (d !== 32'h12345678) begin
            miscompares++;
            $display("FAIL same_edge_after got %h need 12345678", d);
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] d;
        logic [1:0]  r;
        @(negedge aclk);
        awaddr  = 12'h030;
        wdata   = 32'h00000077;
        wstrb   = 4'hF;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        bready  = 1'b0;
        araddr  = 12'h010;
        arvalid = 1'b1;
        rready  = 1'b0;
        @(posedge aclk); #1;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        arvalid = 1'b0;
        @(negedge aclk);
        vectors++;
        if ({bvalid, rvalid} !== 2'b11) begin
            miscompares++;
            $display("FAIL pre_reset_valid got %b need 11", {bvalid, rvalid});
        end
        #2 areset_n = 1'b0;
        #1;
        vectors++;
        if ({bvalid, rvalid} !== 2'b00 || rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL async_reset got %b/%h need 00/00000000", {bvalid, rvalid}, rdata);
        end
        @(negedge aclk);
        areset_n = 1'b1;
        @(posedge aclk); #1;
        do_read(12'h010, d, r);
        vectors++;
        if (d !== 32'h0 || r !== RESP_OKAY) begin
            miscompares++;
            $display("FAIL post_reset_read got %h/%b need 00000000/00", d, r);
        end
        do_read(12'h030, d, r);
        vectors++;
        if (d !== 32'h0) begin
            miscompares++;
            $display("FAIL post_reset_word30 got %h need 00000000", d);
        end
    endtask

    initial begin
        test_reset();
        test_w_before_aw();
        test_strobes();
        test_out_of_range();
        test_concurrency();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
